pgm_arbiter: RTL and testbench
==============================

PGM_ARBITER -- requirements
Module: pgm_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: cycles that cpu_reset stays asserted after a load session ends (1..65535).
REQ-002 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  in  1: reset is synchronous and active-low.
REQ-004 SHALL have ports a_req / b_req  in  1 each: requester A (JTAG loader) / B (serial loader) session request, held high for the whole session.
REQ-005 SHALL have ports a_addr / b_addr  in  16 each: program-memory word address.
REQ-006 SHALL have ports a_data / b_data  in  16 each: program word.
REQ-007 SHALL have ports a_we / b_we  in  1 each: single-cycle write strobe.
REQ-008 SHALL have ports a_gnt / b_gnt  out  1 each: requester owns the program write port.
REQ-009 SHALL have ports pgm_addr / pgm_data  out  16 each, and pgm_we  out  1: program write port toward the j1 CPU.
REQ-010 SHALL have port cpu_reset  out  1: active-high hold of the CPU while loading.
REQ-011 SHALL have port drop_err  out  1: sticky flag for discarded writes.
REQ-012 SHALL have port checksum  out  16: session checksum (see Configuration).

Function
REQ-013 SHALL implement states IDLE, OWN_A, OWN_B and HOLD.
REQ-014 IDLE: a_req only -> OWN_A; b_req only -> OWN_B; both -> requester not served last (rr flag), A first after reset; neither -> stay.
REQ-015 a_gnt SHALL be 1 exactly in OWN_A and b_gnt exactly in OWN_B; both grants are registered and never 1 together.
REQ-016 In OWN_x, a x_we SHALL produce pgm_we=1 with pgm_addr/pgm_data = x_addr/x_data exactly one cycle later (registered, latency 1).
REQ-017 pgm_we SHALL be 0 in every cycle without a forwarded write; pgm_addr/pgm_data SHALL hold their last values.
REQ-018 A write strobe from a requester not currently granted (including the grant cycle itself and HOLD) SHALL be discarded and SHALL set drop_err.
REQ-019 drop_err SHALL clear only on reset.
REQ-020 OWN_x with x_req=0 SHALL go to HOLD, set rr to x, and load the hold counter with HOLD_CYCLES-1; the other requester waits.
REQ-021 HOLD SHALL decrement the counter each cycle and go to IDLE in the cycle after it reads 0.
REQ-022 A request arriving in HOLD SHALL abort the counter and grant directly, using the REQ-014 rules.
REQ-023 cpu_reset SHALL be registered and equal 1 whenever next state is not IDLE; it SHALL be 0 only in IDLE.
REQ-024 A session-ending request drop and a write strobe in the same cycle: the write SHALL still be forwarded, because the requester is still granted in that cycle.
REQ-025 The hold counter SHALL be 16 bits and SHALL not wrap below 0.

Reset
REQ-026 With reset_n=0 at a clock edge, the following SHALL be set:
  - state HOLD, counter HOLD_CYCLES-1, rr=B (A served first);
  - a_gnt=b_gnt=0, pgm_we=0, pgm_addr=pgm_data=0;
  - cpu_reset=1, drop_err=0, checksum=0.
REQ-027 Reset asserted mid-session SHALL abort the session immediately; no further pgm_we SHALL occur while reset_n=0.
REQ-028 After reset release, cpu_reset SHALL remain 1 for HOLD_CYCLES cycles unless a request arrives first.

Configuration
REQ-029 Macro PGM_ARBITER_CHECKSUM_EN SHALL control the checksum feature.
  - Defined: checksum is cleared to 0 on entry to OWN_A/OWN_B and adds pgm_data (mod 2^16) in each cycle pgm_we=1. It holds its value through HOLD/IDLE until the next grant.
  - Undefined: checksum is constant 0 and no adder logic is present.

Verification
REQ-030 Bench SHALL cover the following scenarios:
  - Reset release, no requests, HOLD_CYCLES=16 -> cpu_reset=1 for 16 cycles, then 0; pgm_we never 1.
  - a_req=1, writes (0x0000,0x1234),(0x0001,0xABCD) -> a_gnt next cycle; each pgm_we one cycle after a_we with matching addr/data; checksum=0xBE01 when enabled.
  - a_req and b_req rise in the same cycle after reset -> A granted; A drops -> HOLD, then B granted with no IDLE cycle; cpu_reset stays 1 throughout.
  - b_we pulsed while A owns the port -> no pgm_we for it; drop_err=1 and stays 1 until reset.
  - reset_n=0 during an A session with a_we=1 -> pgm_we=0, a_gnt=0, cpu_reset=1 on the next edge.
  - Build without PGM_ARBITER_CHECKSUM_EN, repeat the second scenario -> checksum stays 0x0000; all other responses identical.

Source files
------------

// File: rtl/pgm_arbiter.sv
// Program-memory write arbiter between a JTAG loader (A) and a serial loader (B) for the j1 CPU.
// Optional session checksum is enabled by defining PGM_ARBITER_CHECKSUM_EN.
module pgm_arbiter #(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_data,
  input  logic        a_we,
  input  logic        b_req,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_data,
  input  logic        b_we,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic [15:0] pgm_addr,
  output logic [15:0] pgm_data,
  output logic        pgm_we,
  output logic        cpu_reset,
  output logic        drop_err,
  output logic [15:0] checksum
);

  // state    | meaning
  // IDLE     | no session, CPU running
  // OWN_A    | loader A owns the program write port
  // OWN_B    | loader B owns the program write port
  // HOLD     | session ended, CPU still held in reset while counter runs
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);

  logic [1:0]  state_q, state_d, pick;
  logic [15:0] cnt_q, cnt_d;
  logic        rr_q, rr_d;
  logic        a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic        pgm_we_q, pgm_we_d;
  logic [15:0] pgm_addr_q, pgm_addr_d, pgm_data_q, pgm_data_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        drop_err_q, drop_err_d;
  logic        fwd_a, fwd_b;

  always_comb begin
    // rr_q names the requester served last, so a tie goes to the other one
    pick = ST_IDLE;
    if (a_req && (!b_req || rr_q == RR_B)) pick = ST_OWN_A;
    else if (b_req)                        pick = ST_OWN_B;

    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: state_d = pick;
      ST_OWN_A: begin
        if (!a_req) begin
          state_d = ST_HOLD;
          rr_d    = RR_A;
          cnt_d   = HOLD_INIT;
        end
      end
      ST_OWN_B: begin
        if (!b_req) begin
          state_d = ST_HOLD;
          rr_d    = RR_B;
          cnt_d   = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (a_req || b_req)   state_d = pick;
        else if (cnt_q == '0) state_d = ST_IDLE;
        else                  cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // the owner is decided by the current state, so a write in the grant cycle or in HOLD is dropped
    fwd_a = (state_q == ST_OWN_A) && a_we;
    fwd_b = (state_q == ST_OWN_B) && b_we;
    pgm_we_d   = fwd_a || fwd_b;
    pgm_addr_d = pgm_addr_q;
    pgm_data_d = pgm_data_q;
    if (fwd_a) begin
      pgm_addr_d = a_addr;
      pgm_data_d = a_data;
    end else if (fwd_b) begin
      pgm_addr_d = b_addr;
      pgm_data_d = b_data;
    end
    drop_err_d  = drop_err_q || (a_we && !fwd_a) || (b_we && !fwd_b);
    a_gnt_d     = (state_d == ST_OWN_A);
    b_gnt_d     = (state_d == ST_OWN_B);
    cpu_reset_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_HOLD;
      cnt_q       <= HOLD_INIT;
      rr_q        <= RR_B;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      pgm_we_q    <= 1'b0;
      pgm_addr_q  <= '0;
      pgm_data_q  <= '0;
      cpu_reset_q <= 1'b1;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      pgm_we_q    <= pgm_we_d;
      pgm_addr_q  <= pgm_addr_d;
      pgm_data_q  <= pgm_data_d;
      cpu_reset_q <= cpu_reset_d;
      drop_err_q  <= drop_err_d;
    end
  end

`ifdef PGM_ARBITER_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;
  logic        enter_own;

  always_comb begin
    enter_own  = (state_d == ST_OWN_A && state_q != ST_OWN_A) ||
                 (state_d == ST_OWN_B && state_q != ST_OWN_B);
    checksum_d = checksum_q;
    if (enter_own)     checksum_d = '0;
    else if (pgm_we_q) checksum_d = checksum_q + pgm_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign pgm_we    = pgm_we_q;
  assign pgm_addr  = pgm_addr_q;
  assign pgm_data  = pgm_data_q;
  assign cpu_reset = cpu_reset_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_pgm_arbiter.sv
// Directed bench for pgm_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_pgm_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, b_req, a_we, b_we;
  logic [15:0] a_addr, a_data, b_addr, b_data;
  logic        a_gnt, b_gnt, pgm_we, cpu_reset, drop_err;
  logic [15:0] pgm_addr, pgm_data, checksum;

  int checks = 0;
  int errors = 0;

`ifdef PGM_ARBITER_CHECKSUM_EN
  localparam logic [15:0] EXP_SUM = 16'hBE01;
`else
  localparam logic [15:0] EXP_SUM = 16'h0000;
`endif

  pgm_arbiter #(.HOLD_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_we(a_we),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_we(b_we),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .pgm_addr(pgm_addr), .pgm_data(pgm_data),
    .pgm_we(pgm_we), .cpu_reset(cpu_reset), .drop_err(drop_err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = 0; a_data = 0; b_addr = 0; b_data = 0;
    cyc(); cyc();
  endtask

  // counts falling edges with cpu_reset high, starting at the current one
  task automatic count_hold(input string name, input int exp_n);
    int n = 0;
    int we_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (pgm_we !== 1'b0) we_seen++;
      if (cpu_reset !== 1'b1) break;
      n++;
      cyc();
    end
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL %s_hold_len got %0d want %0d", name, n, exp_n);
    end
    checks++;
    if (cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle cpu_reset got %b want 0", name, cpu_reset);
    end
    checks++;
    if (we_seen !== 0) begin
      errors++;
      $display("FAIL %s_no_we pgm_we pulses got %0d want 0", name, we_seen);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({a_gnt, b_gnt, pgm_we, cpu_reset, drop_err} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_flags got %b want 00010", {a_gnt, b_gnt, pgm_we, cpu_reset, drop_err});
    end
    checks++;
    if ({pgm_addr, pgm_data, checksum} !== 48'h0) begin
      errors++;
      $display("FAIL reset_words got %h want 0", {pgm_addr, pgm_data, checksum});
    end
    reset_n = 1'b1;
    count_hold("release", 16);
  endtask

  task automatic test_single_a();
    apply_reset();
    reset_n = 1'b1;
    a_req = 1'b1;
    cyc();
    checks++;
    if ({a_gnt, b_gnt, cpu_reset} !== 3'b101) begin
      errors++;
      $display("FAIL a_grant got %b want 101", {a_gnt, b_gnt, cpu_reset});
    end
    a_we = 1'b1; a_addr = 16'h0000; a_data = 16'h1234;
    cyc();
    checks++;
    if ({pgm_we, pgm_addr, pgm_data} !== {1'b1, 16'h0000, 16'h1234}) begin
      errors++;
      $display("FAIL a_wr0 got %b %h %h want 1 0000 1234", pgm_we, pgm_addr, pgm_data);
    end
    a_addr = 16'h0001; a_data = 16'hABCD;
    cyc();
    checks++;
    if ({pgm_we, pgm_addr, pgm_data} !== {1'b1, 16'h0001, 16'hABCD}) begin
      errors++;
      $display("FAIL a_wr1 got %b %h %h want 1 0001 abcd", pgm_we, pgm_addr, pgm_data);
    end
    a_we = 1'b0; a_addr = 16'h5555; a_data = 16'h6666;
    cyc();
    checks++;
    if ({pgm_we, pgm_addr, pgm_data, drop_err} !== {1'b0, 16'h0001, 16'hABCD, 1'b0}) begin
      errors++;
      $display("FAIL a_idle_hold got %b %h %h %b want 0 0001 abcd 0", pgm_we, pgm_addr, pgm_data, drop_err);
    end
    checks++;
    if (checksum !== EXP_SUM) begin
      errors++;
      $display("FAIL a_checksum got %h want %h", checksum, EXP_SUM);
    end
    a_req = 1'b0;
    cyc();
    checks++;
    if ({a_gnt, b_gnt, cpu_reset} !== 3'b001) begin
      errors++;
      $display("FAIL a_end_hold got %b want 001", {a_gnt, b_gnt, cpu_reset});
    end
    count_hold("a_end", 16);
    checks++;
    if (checksum !== EXP_SUM) begin
      errors++;
      $display("FAIL a_checksum_idle got %h want %h", checksum, EXP_SUM);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    reset_n = 1'b1;
    a_req = 1'b1; b_req = 1'b1;
    cyc();
    checks++;
    if ({a_gnt, b_gnt, cpu_reset} !== 3'b101) begin
      errors++;
      $display("FAIL tie_grant_a got %b want 101", {a_gnt, b_gnt, cpu_reset});
    end
    a_req = 1'b0;
    cyc();
    checks++;
    if ({a_gnt, b_gnt, cpu_reset} !== 3'b001) begin
      errors++;
      $display("FAIL tie_hold got %b want 001", {a_gnt, b_gnt, cpu_reset});
    end
    cyc();
    checks++;
    if ({a_gnt, b_gnt, cpu_reset} !== 3'b011) begin
      errors++;
      $display("FAIL tie_grant_b got %b want 011", {a_gnt, b_gnt, cpu_reset});
    end
    // B was served last, so a fresh tie after B ends goes to A
    a_req = 1'b1; b_req = 1'b0;
    cyc();
    checks++;
    if ({a_gnt, b_gnt, cpu_reset} !== 3'b001) begin
      errors++;
      $display("FAIL b_end_hold got %b want 001", {a_gnt, b_gnt, cpu_reset});
    end
    b_req = 1'b1;
    cyc();
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL rr_grant_a got %b want 10", {a_gnt, b_gnt});
    end
  endtask

  task automatic test_drop();
    apply_reset();
    reset_n = 1'b1;
    a_req = 1'b1;
    a_we = 1'b1; a_addr = 16'h0009; a_data = 16'h9999;
    cyc();
    checks++;
    if ({pgm_we, drop_err, a_gnt} !== 3'b011) begin
      errors++;
      $display("FAIL grant_cycle_drop got %b want 011", {pgm_we, drop_err, a_gnt});
    end
    apply_reset();
    reset_n = 1'b1;
    a_req = 1'b1;
    cyc();
    b_we = 1'b1; b_addr = 16'h0005; b_data = 16'h5555;
    cyc();
    checks++;
    if ({pgm_we, drop_err, pgm_addr} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL b_drop got %b %b %h want 0 1 0000", pgm_we, drop_err, pgm_addr);
    end
    b_we = 1'b0;
    // session end and final write in the same cycle: write still goes through
    a_req = 1'b0; a_we = 1'b1; a_addr = 16'h0042; a_data = 16'hC0DE;
    cyc();
    checks++;
    if ({pgm_we, pgm_addr, pgm_data, a_gnt} !== {1'b1, 16'h0042, 16'hC0DE, 1'b0}) begin
      errors++;
      $display("FAIL last_write got %b %h %h %b want 1 0042 c0de 0", pgm_we, pgm_addr, pgm_data, a_gnt);
    end
    a_we = 1'b0;
    cyc(); cyc();
    checks++;
    if (drop_err !== 1'b1) begin
      errors++;
      $display("FAIL drop_sticky got %b want 1", drop_err);
    end
    apply_reset();
    checks++;
    if (drop_err !== 1'b0) begin
      errors++;
      $display("FAIL drop_clear got %b want 0", drop_err);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    reset_n = 1'b1;
    a_req = 1'b1;
    cyc();
    a_we = 1'b1; a_addr = 16'h0007; a_data = 16'h7777;
    reset_n = 1'b0;
    cyc();
    checks++;
    if ({pgm_we, a_gnt, cpu_reset} !== 3'b001) begin
      errors++;
      $display("FAIL mid_reset got %b want 001", {pgm_we, a_gnt, cpu_reset});
    end
    cyc();
    checks++;
    if ({pgm_we, pgm_addr} !== {1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL mid_reset_hold got %b %h want 0 0000", pgm_we, pgm_addr);
    end
    a_we = 1'b0; a_req = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
